// File: rtl/object_line_evaluator_m.sv
// Object line evaluator: scans OBM for objects on the next scanline,
// fetches their PMF pattern rows, applies flips and writes slot entries.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, line_yp      begin evaluation of scanline line_yp (IDLE only)
//   obm_addr, obm_data  object memory read port (1-cycle latency)
//   pmf_addr, pmf_data  pattern memory read port (1-cycle latency)
//   slot_we..slot_line  slot list write port
//   slot_count          slots written this line
//   overflow            more hits than slots on this line
//   busy, done          scan in progress / 1-cycle end-of-scan pulse
module object_line_evaluator_m #(
    parameter int NUM_OBJECTS = 64,
    parameter int MAX_SLOTS   = 8,
    localparam int SW = $clog2(MAX_SLOTS),
    localparam int OW = $clog2(NUM_OBJECTS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    line_yp,
    output logic [7:0]    obm_addr,
    input  logic [7:0]    obm_data,
    output logic [8:0]    pmf_addr,
    input  logic [7:0]    pmf_data,
    output logic          slot_we,
    output logic [SW-1:0] slot_idx,
    output logic [7:0]    slot_xp,
    output logic [2:0]    slot_color,
    output logic [15:0]   slot_line,
    output logic [SW:0]   slot_count,
    output logic          overflow,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE, CHK, ATTR, XP, COL, EMIT, DONE
    } state_t;

    localparam logic [OW-1:0] LAST = OW'(NUM_OBJECTS - 1);
    localparam logic [SW:0]   FULL = (SW+1)'(MAX_SLOTS);

    state_t state, state_d;

    // wt marks the cycle in which a just-issued read is still in flight
    logic          wt, wt_d;
    logic [OW-1:0] obj, obj_d;
    logic [7:0]    ly, ly_d;
    logic [2:0]    row, row_d;
    logic          hf, hf_d;
    logic [4:0]    pmfa, pmfa_d;
    logic [7:0]    xp, xp_d;
    logic [7:0]    hi, hi_d;

    logic [7:0]    obm_addr_d;
    logic [8:0]    pmf_addr_d;
    logic          slot_we_d;
    logic [SW-1:0] slot_idx_d;
    logic [7:0]    slot_xp_d;
    logic [2:0]    slot_color_d;
    logic [15:0]   slot_line_d;
    logic [SW:0]   cnt_d;
    logic          ovf_d;
    logic          busy_d;
    logic          done_d;

    logic [8:0]    dy;
    logic          hit;
    logic [2:0]    rowv;
    logic [15:0]   raw;

    // pixel n <-> pixel 7-n, bit order inside a pixel preserved
    function automatic logic [15:0] prev(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[15-2*i -: 2] = v[2*i+1 -: 2];
        return r;
    endfunction

    // borrow in dy[8] means yp lies below this line: no wrap-around
    assign dy   = {1'b0, ly} - {1'b0, obm_data};
    assign hit  = !dy[8] && (dy[7:3] == 5'd0);
    assign rowv = obm_data[5] ? ~row : row;
    assign raw  = {hi, pmf_data};

    always_comb begin
        state_d      = state;
        wt_d         = wt;
        obj_d        = obj;
        ly_d         = ly;
        row_d        = row;
        hf_d         = hf;
        pmfa_d       = pmfa;
        xp_d         = xp;
        hi_d         = hi;
        obm_addr_d   = obm_addr;
        pmf_addr_d   = pmf_addr;
        slot_we_d    = 1'b0;
        slot_idx_d   = slot_idx;
        slot_xp_d    = slot_xp;
        slot_color_d = slot_color;
        slot_line_d  = slot_line;
        cnt_d        = slot_count;
        ovf_d        = overflow;
        busy_d       = busy;
        done_d       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    ly_d       = line_yp;
                    obj_d      = '0;
                    cnt_d      = '0;
                    ovf_d      = 1'b0;
                    obm_addr_d = {{OW{1'b0}}, 2'd1};
                    wt_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = CHK;
                end
            end
            CHK: begin
                if (wt) begin
                    wt_d = 1'b0;
                end else if (!hit) begin
                    if (obj == LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        obj_d      = obj + 1'b1;
                        obm_addr_d = {obj + 1'b1, 2'd1};
                        wt_d       = 1'b1;
                    end
                end else if (slot_count == FULL) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    row_d      = dy[2:0];
                    obm_addr_d = {obj, 2'd2};
                    wt_d       = 1'b1;
                    state_d    = ATTR;
                end
            end
            ATTR: begin
                if (wt) begin
                    wt_d = 1'b0;
                end else begin
                    hf_d       = obm_data[6];
                    pmfa_d     = obm_data[4:0];
                    row_d      = rowv;
                    obm_addr_d = {obj, 2'd0};
                    pmf_addr_d = {obm_data[4:0], rowv, 1'b0};
                    wt_d       = 1'b1;
                    state_d    = XP;
                end
            end
            XP: begin
                if (wt) begin
                    wt_d = 1'b0;
                end else begin
                    xp_d       = obm_data;
                    hi_d       = pmf_data;
                    obm_addr_d = {obj, 2'd3};
                    pmf_addr_d = {pmfa, row, 1'b1};
                    wt_d       = 1'b1;
                    state_d    = COL;
                end
            end
            COL: begin
                if (wt) begin
                    wt_d = 1'b0;
                end else begin
                    slot_we_d    = 1'b1;
                    slot_idx_d   = slot_count[SW-1:0];
                    cnt_d        = slot_count + 1'b1;
                    slot_xp_d    = xp;
                    slot_color_d = obm_data[2:0];
                    slot_line_d  = hf ? prev(raw) : raw;
                    state_d      = EMIT;
                end
            end
            EMIT: begin
                if (obj == LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    obj_d      = obj + 1'b1;
                    obm_addr_d = {obj + 1'b1, 2'd1};
                    wt_d       = 1'b1;
                    state_d    = CHK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wt         <= 1'b0;
            obj        <= '0;
            ly         <= '0;
            row        <= '0;
            hf         <= 1'b0;
            pmfa       <= '0;
            xp         <= '0;
            hi         <= '0;
            obm_addr   <= '0;
            pmf_addr   <= '0;
            slot_we    <= 1'b0;
            slot_idx   <= '0;
            slot_xp    <= '0;
            slot_color <= '0;
            slot_line  <= '0;
            slot_count <= '0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            wt         <= wt_d;
            obj        <= obj_d;
            ly         <= ly_d;
            row        <= row_d;
            hf         <= hf_d;
            pmfa       <= pmfa_d;
            xp         <= xp_d;
            hi         <= hi_d;
            obm_addr   <= obm_addr_d;
            pmf_addr   <= pmf_addr_d;
            slot_we    <= slot_we_d;
            slot_idx   <= slot_idx_d;
            slot_xp    <= slot_xp_d;
            slot_color <= slot_color_d;
            slot_line  <= slot_line_d;
            slot_count <= cnt_d;
            overflow   <= ovf_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_object_line_evaluator_m.sv
// Testbench for object_line_evaluator_m: directed scans with a slot
// scoreboard checked by an independent monitor.
module tb_object_line_evaluator_m;

    logic        clk = 0;
    logic        rst = 1;
    logic        start = 0;
    logic [7:0]  line_yp = 0;
    logic [7:0]  obm_addr;
    logic [7:0]  obm_data;
    logic [8:0]  pmf_addr;
    logic [7:0]  pmf_data;
    logic        slot_we;
    logic [2:0]  slot_idx;
    logic [7:0]  slot_xp;
    logic [2:0]  slot_color;
    logic [15:0] slot_line;
    logic [3:0]  slot_count;
    logic        overflow;
    logic        busy;
    logic        done;

    object_line_evaluator_m dut (
        .clk(clk), .rst(rst), .start(start), .line_yp(line_yp),
        .obm_addr(obm_addr), .obm_data(obm_data),
        .pmf_addr(pmf_addr), .pmf_data(pmf_data),
        .slot_we(slot_we), .slot_idx(slot_idx), .slot_xp(slot_xp),
        .slot_color(slot_color), .slot_line(slot_line),
        .slot_count(slot_count), .overflow(overflow),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] obm [256];
    logic [7:0] pmf [512];

    always @(posedge clk) begin
        obm_data <= obm[obm_addr];
        pmf_data <= pmf[pmf_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    bit seen9 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // {idx, xp, color, line}
    logic [29:0] exp_q[$];

    always @(negedge clk) begin
        if (busy && obm_addr[7:2] == 6'd9) seen9 = 1;
        if (!rst && slot_we) begin
            logic [29:0] act, ex;
            act = {slot_idx, slot_xp, slot_color, slot_line};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL slot_unexpected: got %h, required none",
                         act);
            end else begin
                ex = exp_q.pop_front();
                if (act !== ex) begin
                    errors++;
                    $display("FAIL slot: got %h, required %h", act, ex);
                end
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, ex);
        end
    endtask

    task automatic pulse_start(input logic [7:0] l);
        @(posedge clk);
        #1;
        start = 1;
        line_yp = l;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - start_cyc;
                break;
            end
        end
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL done_timeout: got none, required done");
        end
    endtask

    task automatic scan(input string name, input logic [7:0] l,
                        input int cnt, input bit ovf);
        int lat;
        pulse_start(l);
        wait_done(lat);
        chk({name, "_count"}, 32'(slot_count), 32'(cnt));
        chk({name, "_ovf"}, 32'(overflow), 32'(ovf));
        chk({name, "_left"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++)
            obm[i] = ((i % 4) == 1) ? 8'hF0 : 8'h00;
        for (int i = 0; i < 512; i++) pmf[i] = 8'h00;
    endtask

    task automatic setup_obj5(input logic [7:0] attr);
        clear_mem();
        obm[8'(5*4+0)] = 8'h20;
        obm[8'(5*4+1)] = 8'h10;
        obm[8'(5*4+2)] = attr;
        obm[8'(5*4+3)] = 8'h05;
    endtask

    task automatic setup_ten();
        clear_mem();
        for (int i = 0; i < 10; i++) begin
            obm[4*i+0] = 8'(i * 8);
            obm[4*i+1] = 8'h40;
            obm[4*i+2] = 8'(i);
            obm[4*i+3] = 8'(i);
            pmf[16*i]   = 8'(i + 1);
            pmf[16*i+1] = 8'(8'hA0 + i);
        end
    endtask

    task automatic push_ten();
        for (int i = 0; i < 8; i++)
            exp_q.push_back({3'(i), 8'(i * 8), 3'(i),
                             8'(i + 1), 8'(8'hA0 + i)});
    endtask

    initial begin
        int lat;
        #2_000_000;
        $display("FAIL global_timeout: got hang, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("rst_outs",
            {busy, done, slot_we, overflow, slot_count, obm_addr, pmf_addr},
            0);
        chk("rst_slot", {slot_idx, slot_xp, slot_color, slot_line}, 0);

        // 1: nothing on the line, full-length scan
        pulse_start(8'h10);
        wait_done(lat);
        chk("t1_latency", 32'(lat), 129);
        chk("t1_busy_at_done", 32'(busy), 0);
        chk("t1_count", 32'(slot_count), 0);
        chk("t1_ovf", 32'(overflow), 0);

        // 2: single plain object
        setup_obj5(8'h03);
        pmf[9'h034] = 8'h1B;
        pmf[9'h035] = 8'hE4;
        exp_q.push_back({3'd0, 8'h20, 3'd5, 16'h1BE4});
        scan("t2", 8'h12, 1, 0);

        // 3a: horizontal flip
        setup_obj5(8'h43);
        pmf[9'h034] = 8'h1B;
        pmf[9'h035] = 8'h00;
        exp_q.push_back({3'd0, 8'h20, 3'd5, 16'h00E4});
        scan("t3h", 8'h12, 1, 0);

        // 3b: vertical flip reads row 5
        setup_obj5(8'h23);
        pmf[9'h034] = 8'h1B;
        pmf[9'h035] = 8'hE4;
        pmf[9'h03A] = 8'hAA;
        pmf[9'h03B] = 8'h55;
        exp_q.push_back({3'd0, 8'h20, 3'd5, 16'hAA55});
        scan("t3v", 8'h12, 1, 0);

        // 4: overflow, obj9 never read
        setup_ten();
        push_ten();
        seen9 = 0;
        pulse_start(8'h40);
        @(negedge clk);
        chk("t4_busy", 32'(busy), 1);
        wait_done(lat);
        chk("t4_count", 32'(slot_count), 8);
        chk("t4_ovf", 32'(overflow), 1);
        chk("t4_left", 32'(exp_q.size()), 0);
        chk("t4_no_obj9", 32'(seen9), 0);
        exp_q.delete();

        // 5: vertical boundaries
        clear_mem();
        obm[0] = 8'h33;
        obm[1] = 8'hFC;
        obm[2] = 8'h01;
        obm[3] = 8'h02;
        pmf[22] = 8'h12;
        pmf[23] = 8'h34;
        pmf[30] = 8'h56;
        pmf[31] = 8'h78;
        exp_q.push_back({3'd0, 8'h33, 3'd2, 16'h1234});
        scan("t5_ff", 8'hFF, 1, 0);
        scan("t5_03", 8'h03, 0, 0);
        obm[1] = 8'h10;
        exp_q.push_back({3'd0, 8'h33, 3'd2, 16'h5678});
        scan("t5_17", 8'h17, 1, 0);
        scan("t5_18", 8'h18, 0, 0);

        // 6a: start while busy is ignored
        setup_ten();
        push_ten();
        pulse_start(8'h40);
        repeat (5) @(posedge clk);
        #1;
        start = 1;
        line_yp = 8'h00;
        @(posedge clk);
        #1;
        start = 0;
        wait_done(lat);
        chk("t6_count", 32'(slot_count), 8);
        chk("t6_ovf", 32'(overflow), 1);
        chk("t6_left", 32'(exp_q.size()), 0);
        exp_q.delete();

        // 6b: reset during the emit cycle
        setup_obj5(8'h03);
        pmf[9'h034] = 8'h1B;
        pmf[9'h035] = 8'hE4;
        exp_q.push_back({3'd0, 8'h20, 3'd5, 16'h1BE4});
        pulse_start(8'h12);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (slot_we) begin
                lat = i;
                break;
            end
        end
        chk("t6_emit_seen", 32'(lat >= 0), 1);
        rst = 1;
        @(negedge clk);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_we", 32'(slot_we), 0);
        chk("t6_rst_count", 32'(slot_count), 0);
        rst = 0;
        repeat (20) @(negedge clk);
        chk("t6_rst_idle", {busy, done, slot_we}, 0);
        exp_q.delete();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
